// File: rtl/mux_pkg.sv
// Shared constants, lock-state encoding and index helper for the N:1 round-robin stream mux.
package mux_pkg;

  localparam int MUX_DATA_WIDTH_DEF = 8;
  localparam int MUX_NUM_CH_DEF     = 4;

  localparam logic LOCK_IDLE = 1'b0;
  localparam logic LOCK_HELD = 1'b1;

  // Sized for the widest legal channel count (16); callers zero-extend and truncate.
  function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin search from ptr+1, or a forced single-channel pick.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = MUX_NUM_CH_DEF,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              force_en,
  input  logic [CH_W-1:0]   force_sel,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [NUM_CH-1:0] rr_grant;
  logic [NUM_CH-1:0] force_grant;

  // Out-of-range force_sel values match no bit, so nothing is granted.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_force
      assign force_grant[gi] = req[gi] && (force_sel == CH_W'(gi));
    end
  endgenerate

  always_comb begin
    logic found;
    int   idx;
    rr_grant = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && req[idx]) begin
        rr_grant[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign grant     = force_en ? force_grant : rr_grant;
  assign grant_idx = CH_W'(onehot2idx(16'(grant)));

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 valid/ready stream mux with registered output, round-robin or forced selection.
// Optional packet lock (in_last/out_last ports) is enabled by defining MUX_PKT_LOCK_EN.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter  int DATA_WIDTH = MUX_DATA_WIDTH_DEF,
  parameter  int NUM_CH     = MUX_NUM_CH_DEF,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
`ifdef MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]            in_last,
  output logic                         out_last,
`endif
  input  logic                         force_en,
  input  logic [CH_W-1:0]              force_sel,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  input  logic                         out_ready
);

  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [CH_W-1:0]       out_ch_reg;
  logic [CH_W-1:0]       ptr_reg;

  logic [NUM_CH-1:0]     arb_grant;
  logic [CH_W-1:0]       arb_idx;
  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       grant_idx;
  logic                  load;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] data_arr [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign data_arr[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_reg),
    .force_en  (force_en),
    .force_sel (force_sel),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

`ifdef MUX_PKT_LOCK_EN
  logic            lock_state_reg, lock_state_next;
  logic [CH_W-1:0] lock_ch_reg, lock_ch_next;
  logic            out_last_reg;

  // A held packet overrides both arbitration modes until its last beat moves.
  assign grant     = (lock_state_reg == LOCK_HELD) ? (in_valid & (NUM_CH'(1) << lock_ch_reg)) : arb_grant;
  assign grant_idx = (lock_state_reg == LOCK_HELD) ? lock_ch_reg : arb_idx;

  always_comb begin
    lock_state_next = lock_state_reg;
    lock_ch_next    = lock_ch_reg;
    if (xfer) begin
      if (lock_state_reg == LOCK_IDLE && !in_last[grant_idx]) begin
        lock_state_next = LOCK_HELD;
        lock_ch_next    = grant_idx;
      end else if (lock_state_reg == LOCK_HELD && in_last[grant_idx]) begin
        lock_state_next = LOCK_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state_reg <= LOCK_IDLE;
      lock_ch_reg    <= '0;
      out_last_reg   <= 1'b0;
    end else begin
      lock_state_reg <= lock_state_next;
      lock_ch_reg    <= lock_ch_next;
      if (xfer) out_last_reg <= in_last[grant_idx];
    end
  end

  assign out_last = out_last_reg;
`else
  assign grant     = arb_grant;
  assign grant_idx = arb_idx;
`endif

  assign load     = !out_valid_reg || out_ready;
  assign in_ready = grant & {NUM_CH{load && !rst}};
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      ptr_reg       <= CH_W'(NUM_CH - 1);
    end else begin
      if (load) out_valid_reg <= xfer;
      if (xfer) begin
        out_data_reg <= data_arr[grant_idx];
        out_ch_reg   <= grant_idx;
        if (!force_en) ptr_reg <= grant_idx;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Randomised bench for mux_nx1_rr with a behavioural reference model plus directed literal checks.
module tb_mux_nx1_rr;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic [N-1:0]  in_last;
  logic          out_last;
  logic          force_en;
  logic [CW-1:0] force_sel;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_nx1_rr #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

`ifndef MUX_PKT_LOCK_EN
  assign out_last = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain state of "what the consumer should see" and the rr pointer.
  int           m_ptr;
  bit           m_valid;
  logic [DW-1:0] m_data;
  int           m_ch;
  bit           m_last;
  bit           m_locked;
  int           m_lock_ch;

  always @(negedge clk) begin
    int g;
    bit ld;
    logic [N-1:0] exp_ready;
    if (rst) begin
      m_ptr = N - 1; m_valid = 0; m_data = '0; m_ch = 0; m_last = 0;
      m_locked = 0; m_lock_ch = 0;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
    end else begin
      ld = !m_valid || out_ready;
      g  = -1;
      if (m_locked) begin
        if (in_valid[m_lock_ch]) g = m_lock_ch;
      end else if (force_en) begin
        if (int'(force_sel) < N && in_valid[force_sel]) g = int'(force_sel);
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      exp_ready = (ld && g >= 0) ? N'(1 << g) : '0;
      chk("m_in_ready", 32'(in_ready), 32'(exp_ready));
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      chk("m_out_data", 32'(out_data), 32'(m_data));
      chk("m_out_ch", 32'(out_ch), 32'(m_ch));
`ifdef MUX_PKT_LOCK_EN
      chk("m_out_last", 32'(out_last), 32'(m_last));
`endif
      if (ld) begin
        if (g >= 0) begin
          m_valid = 1;
          m_data  = in_data[g*DW +: DW];
          m_ch    = g;
          if (!force_en) m_ptr = g;
`ifdef MUX_PKT_LOCK_EN
          m_last = in_last[g];
          if (!m_locked && !in_last[g]) begin
            m_locked = 1; m_lock_ch = g;
          end else if (m_locked && in_last[g]) begin
            m_locked = 0;
          end
`endif
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_last = '0; force_en = 0; force_sel = '0; out_ready = 1;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(i * 8'h11);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_out_ch", 32'(out_ch), 0);
    rst = 1'b0;

    // Round robin over all-valid channels.
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_ch", 32'(out_ch), 32'(i % N));
      chk("rr_data", 32'(out_data), 32'((i % N) * 8'h11));
    end

    // Backpressure after 8'h11 is in the register.
    do_reset();
    tick();
    tick();
    chk("bp_first", 32'(out_data), 32'h11);
    out_ready = 0;
    #1;
    chk("bp_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", 32'(out_data), 32'h11);
    end
    out_ready = 1;
    tick();
    chk("bp_release", 32'(out_data), 32'h22);
    chk("bp_release_v", 32'(out_valid), 1);

    // Mid-stream asynchronous reset.
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    chk("async_rst_ch", 32'(out_ch), 0);
    chk("async_rst_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0;

    // Forced selection.
    force_en = 1; force_sel = 2; in_valid = 4'b0101;
    #1;
    chk("force_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("force_ch_a", 32'(out_ch), 2);
    tick();
    chk("force_ch_b", 32'(out_ch), 2);
    force_sel = 1;
    tick();
    chk("force_empty", 32'(out_valid), 0);
    force_en = 0;

    // Sparse requests.
    do_reset();
    in_valid = 4'b1000;
    tick();
    chk("sparse_v", 32'(out_valid), 1);
    chk("sparse_ch3", 32'(out_ch), 3);
    in_valid = 4'b0101;
    tick();
    chk("sparse_ch0", 32'(out_ch), 0);

`ifdef MUX_PKT_LOCK_EN
    // Packet lock on channel 1 while channel 0 also requests.
    do_reset();
    in_valid = 4'b0010; in_last = 4'b0000;
    tick();
    chk("lock_b0", 32'(out_ch), 1);
    in_valid = 4'b0011;
    tick();
    chk("lock_b1", 32'(out_ch), 1);
    chk("lock_b1_last", 32'(out_last), 0);
    in_last = 4'b0011;
    tick();
    chk("lock_b2", 32'(out_ch), 1);
    chk("lock_b2_last", 32'(out_last), 1);
    tick();
    chk("lock_after", 32'(out_ch), 0);
`endif

    // Random traffic checked by the model every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = N'($urandom);
      in_data   = ($urandom);
      in_last   = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      force_en  = ($urandom_range(0, 3) == 0);
      force_sel = CW'($urandom);
      tick();
    end

    idle_inputs();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-to-1 stream multiplexer with a registered output. It is the successor of the 2:1 data-path mux, generalised to NUM_CH channels and adding valid/ready handshaking, round-robin arbitration and a forced-select mode that reproduces plain `sel` behaviour. It sits between the per-row/per-column operand producers of the 10x10 8-bit array and any shared downstream consumer, such as the result drain or a shared adder.

## Interface
- DATA_WIDTH, 8, bits per data word.
- NUM_CH, 4, number of input channels; legal range 2..16.
- CH_W (localparam), $clog2(NUM_CH), width of a channel index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel valid; bit i belongs to channel i.
- in_data  in  NUM_CH*DATA_WIDTH  flattened data; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  NUM_CH  per-channel ready; at most one bit is high per cycle.
- force_en  in  1  1 = forced-select mode, 0 = round-robin mode.
- force_sel  in  CH_W  channel served while force_en=1.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_WIDTH  registered data.
- out_ch  out  CH_W  source channel of out_data.
- out_ready  in  1  consumer accepts the word.
- in_last  in  NUM_CH  present only with MUX_PKT_LOCK_EN; end-of-packet flag per channel.
- out_last  out  1  present only with MUX_PKT_LOCK_EN; registered copy of the granted in_last bit.

## Operation
- The output register has two states. EMPTY means out_valid=0; FULL means out_valid=1.
- load = !out_valid || out_ready. A new word may enter only when load=1.
- grant (one-hot, NUM_CH bits) is combinational. in_ready = grant & {NUM_CH{load}}. Transfer on channel i occurs when in_valid[i] && in_ready[i].
- Round-robin mode (force_en=0):
  - Search starts at ptr+1 and wraps modulo NUM_CH. The first valid channel found is granted.
  - ptr updates to the granted index only on a transfer.
  - ptr resets to NUM_CH-1, so channel 0 has first priority after reset.
- Forced mode (force_en=1):
  - grant = in_valid[force_sel] at bit force_sel.
  - If force_sel >= NUM_CH, nothing is granted.
  - ptr does not change while force_en=1.
- On a transfer, the register loads out_data=in_data[ch], out_ch=ch and out_valid=1.
- If load=1 and no channel transfers, out_valid goes to 0. out_data and out_ch hold their previous values.
- Simultaneous pop and push (out_valid && out_ready with a new transfer in the same cycle) leaves out_valid at 1 and loads the new word with no bubble.
- force_en and force_sel are sampled every cycle. A change takes effect in the next grant decision; the word already in the output register is never modified.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, out_last=0, ptr=NUM_CH-1, lock state IDLE.
- in_ready is also 0 while rst=1.
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 word per cycle while out_ready=1.
- in_ready depends combinationally on out_ready and in_valid. It must not depend on in_data.
- A reset asserted mid-stream clears the held word immediately, because the reset is asynchronous. Release of reset is synchronised by the system.

## Configuration
- The macro is MUX_PKT_LOCK_EN.
- When defined, the in_last/out_last ports exist and a lock FSM is added:
  - IDLE goes to LOCK(ch) on a transfer with in_last[ch]=0.
  - LOCK(ch) grants only ch, in both round-robin and forced mode.
  - LOCK(ch) returns to IDLE on a transfer with in_last[ch]=1.
  - out_last registers alongside out_data.
  - Reset returns the FSM to IDLE.
- When undefined, every word is arbitrated independently and the in_last/out_last ports are absent.

## Structure
- Package mux_pkg holds:
  - default constants MUX_DATA_WIDTH_DEF=8 and MUX_NUM_CH_DEF=4;
  - lock-state encoding LOCK_IDLE=1'b0, LOCK_HELD=1'b1;
  - function onehot2idx.
- One sub-module, rr_arbiter. Its inputs are req, ptr, force_en and force_sel; its outputs are grant and grant_idx. It is purely combinational.
- The top level owns the output register, ptr and the lock FSM.

## Test plan
- Reset check, NUM_CH=4: assert rst mid-stream while out_valid=1 → out_valid, out_data and out_ch are 0 on the same edge, and in_ready=0.
- Round-robin: in_valid=4'b1111 with data i*8'h11 and out_ready=1 held → out_ch sequence 0,1,2,3,0 with out_data 00,11,22,33,00, one word per cycle.
- Backpressure: out_ready=0 for 3 cycles with all channels valid → out_data holds 8'h11, in_ready=0, and ptr does not change; release out_ready → 8'h22 follows with no bubble.
- Forced mode: force_en=1, force_sel=2, in_valid=4'b0101 → only channel 2 is granted (in_ready=4'b0100), out_ch=2 each cycle. force_sel=1 with in_valid[1]=0 → out_valid=0.
- Sparse requests: in_valid=4'b1000 only → 1-cycle latency, out_ch=3, then ptr=3; next request on channel 0 is granted before a same-cycle request on channel 2.
- With MUX_PKT_LOCK_EN: channel 1 sends 3 beats with in_last=0,0,1 while channel 0 is also valid → out_ch=1,1,1 with out_last on the third beat, then channel 0 is granted.
